vram_write_arbiter: RTL and testbench

- Sits directly downstream of the text-mode write producer (test pattern FSM or CPU bridge) and in front of the single-port display RAM (UP5K SPRAM, 1-cycle read latency).
- Buffers producer write strobes in a small FIFO.
- Commits buffered writes to the RAM only on cycles when the video scan-out is not reading it.
- The producer has no backpressure. Overflow is therefore counted and flagged, never stalled.

---
 rtl/vram_write_arbiter_if.sv | 31 +++
 rtl/vram_write_arbiter.sv | 61 ++++++
 tb/tb_vram_write_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vram_write_arbiter_if.sv
// vram_write_arbiter_if: producer, video-fetch, RAM-port and status signals of the VRAM write arbiter.
// The master modport is the surrounding system; the slave modport is the arbiter itself.
interface vram_write_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              vid_rd_en_i;
    logic [ADDR_W-1:0] vid_rd_addr_i;
    logic [DATA_W-1:0] vid_rd_data_o;
    logic              vid_rd_valid_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_en_o;
    logic [DATA_W-1:0] ram_wr_data_o;
    logic [DATA_W-1:0] ram_rd_data_i;
    logic              busy_o;
    logic              overflow_o;
    logic [7:0]        drop_count_o;
    logic              clr_overflow_i;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, vid_rd_en_i, vid_rd_addr_i, ram_rd_data_i, clr_overflow_i,
        input  vid_rd_data_o, vid_rd_valid_o, ram_addr_o, ram_wr_en_o, ram_wr_data_o, busy_o, overflow_o, drop_count_o
    );
    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, vid_rd_en_i, vid_rd_addr_i, ram_rd_data_i, clr_overflow_i,
        output vid_rd_data_o, vid_rd_valid_o, ram_addr_o, ram_wr_en_o, ram_wr_data_o, busy_o, overflow_o, drop_count_o
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: buffers producer writes in a FIFO and commits them to the single-port
// display RAM only on cycles the video scan-out leaves free; overflow is counted, never stalled.
module vram_write_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input logic                 clk,
    input logic                 reset_n_i,
    vram_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head, r_tail;
    logic [PW:0]       r_count;
    logic [7:0]        r_drops;
    logic              r_overflow, r_vid_valid;
    logic              w_pop, w_push, w_drop;

    // a pop frees the head slot this cycle, so a full FIFO can still take a word
    assign w_pop  = !bus.vid_rd_en_i && r_count != '0;
    assign w_push = bus.wr_en_i && (r_count != FULL || w_pop);
    assign w_drop = bus.wr_en_i && !w_push;

    assign bus.ram_addr_o     = bus.vid_rd_en_i ? bus.vid_rd_addr_i : r_addr[r_head];
    assign bus.ram_wr_en_o    = w_pop;
    assign bus.ram_wr_data_o  = r_data[r_head];
    assign bus.vid_rd_data_o  = bus.ram_rd_data_i;
    assign bus.vid_rd_valid_o = r_vid_valid;
    assign bus.busy_o         = r_count != '0;
    assign bus.overflow_o     = r_overflow;
    assign bus.drop_count_o   = r_drops;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.wr_addr_i;
            r_data[r_tail] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_drops     <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            r_head      <= r_head + PW'(w_pop);
            r_tail      <= r_tail + PW'(w_push);
            r_count     <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            r_overflow  <= w_drop || (r_overflow && !bus.clr_overflow_i);
            // a drop in the same cycle as a clear leaves a count of one
            r_drops     <= bus.clr_overflow_i ? {7'd0, w_drop} : r_drops + 8'(w_drop && r_drops != 8'hFF);
            r_vid_valid <= bus.vid_rd_en_i;
        end
    end
endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb_vram_write_arbiter: directed and random stimulus checked against a queue-based model
// of the arbiter plus a behavioural 1-cycle-latency RAM.
module tb_vram_write_arbiter;
    localparam int DEPTH = 8;
    typedef struct {
        logic [13:0] a;
        logic [15:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n_i = 1'b0;
    vram_write_arbiter_if #(.ADDR_W(14), .DATA_W(16)) bus ();

    vram_write_arbiter #(.ADDR_W(14), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [16384];
    always @(posedge clk) begin
        if (bus.ram_wr_en_o) ram[bus.ram_addr_o] <= bus.ram_wr_data_o;
        else bus.ram_rd_data_i <= ram[bus.ram_addr_o];
    end

    int checks = 0;
    int errors = 0;
    int commits = 0;
    ent_t q[$];
    logic [15:0] gmem [int];
    logic m_ovf = 1'b0;
    int m_drops = 0;
    logic m_vvalid = 1'b0;
    logic m_rd_known = 1'b0;
    logic [15:0] m_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic wen, input logic [13:0] wa, input logic [15:0] wd,
                        input logic vid, input logic [13:0] va, input logic clr);
        logic pop, push;
        bus.wr_en_i = wen;
        bus.wr_addr_i = wa;
        bus.wr_data_i = wd;
        bus.vid_rd_en_i = vid;
        bus.vid_rd_addr_i = va;
        bus.clr_overflow_i = clr;
        #1;
        pop = !vid && q.size() != 0;
        chk("ram_wr_en", 32'(bus.ram_wr_en_o), 32'(pop));
        chk("busy", 32'(bus.busy_o), 32'(q.size() != 0));
        chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
        chk("drop_count", 32'(bus.drop_count_o), m_drops);
        chk("vid_valid", 32'(bus.vid_rd_valid_o), 32'(m_vvalid));
        if (pop) begin
            chk("commit_addr", 32'(bus.ram_addr_o), 32'(q[0].a));
            chk("commit_data", 32'(bus.ram_wr_data_o), 32'(q[0].d));
            commits++;
        end
        if (vid) chk("vid_addr", 32'(bus.ram_addr_o), 32'(va));
        if (m_vvalid && m_rd_known) chk("vid_data", 32'(bus.vid_rd_data_o), 32'(m_rd));
        push = wen && (q.size() < DEPTH || pop);
        if (pop) begin
            gmem[int'(q[0].a)] = q[0].d;
            void'(q.pop_front());
        end
        if (push) q.push_back('{a: wa, d: wd});
        if (wen && !push) begin
            m_ovf = 1'b1;
            m_drops = clr ? 1 : (m_drops == 255 ? 255 : m_drops + 1);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end
        m_vvalid = vid;
        m_rd_known = vid && gmem.exists(int'(va));
        if (m_rd_known) m_rd = gmem[int'(va)];
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int c0;
        bus.wr_en_i = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.vid_rd_en_i = 1'b0;
        bus.vid_rd_addr_i = '0;
        bus.clr_overflow_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(bus.ram_wr_en_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_overflow", 32'(bus.overflow_o), 0);
        chk("rst_drops", 32'(bus.drop_count_o), 0);
        chk("rst_vid_valid", 32'(bus.vid_rd_valid_o), 0);
        reset_n_i = 1'b1;
        @(negedge clk);

        step(1'b1, 14'h0000, 16'h1F48, 1'b0, '0, 1'b0);
        step(1'b1, 14'h0001, 16'h1F65, 1'b0, '0, 1'b0);
        step(1'b1, 14'h0002, 16'h1F6C, 1'b0, '0, 1'b0);
        idle(3);
        chk("t1_busy_after", 32'(bus.busy_o), 0);

        c0 = commits;
        for (int i = 0; i < 20; i++) step(i < 8, 14'(16 + i), 16'($urandom), 1'b1, 14'(i), 1'b0);
        chk("t2_no_commit_in_window", commits, c0);
        idle(9);
        chk("t2_commits", commits - c0, 8);
        chk("t2_overflow", 32'(bus.overflow_o), 0);

        for (int i = 0; i < 11; i++) step(1'b1, 14'(32 + i), 16'($urandom), 1'b1, 14'h0300, 1'b0);
        chk("t3_overflow", 32'(bus.overflow_o), 1);
        chk("t3_drops", 32'(bus.drop_count_o), 3);
        step(1'b0, '0, '0, 1'b1, 14'h0300, 1'b1);
        chk("t3_clr_overflow", 32'(bus.overflow_o), 0);
        chk("t3_clr_drops", 32'(bus.drop_count_o), 0);
        chk("t3_still_busy", 32'(bus.busy_o), 1);

        c0 = commits;
        step(1'b1, 14'h0040, 16'hBEEF, 1'b0, '0, 1'b0);
        chk("t4_no_drop", 32'(bus.drop_count_o), 0);
        chk("t4_no_overflow", 32'(bus.overflow_o), 0);
        idle(10);
        chk("t4_commits", commits - c0, 9);

        step(1'b1, 14'h0100, 16'hA541, 1'b0, '0, 1'b0);
        idle(1);
        step(1'b0, '0, '0, 1'b1, 14'h0100, 1'b0);
        #1;
        chk("t5_valid", 32'(bus.vid_rd_valid_o), 1);
        chk("t5_data", 32'(bus.vid_rd_data_o), 32'h0000A541);
        idle(1);

        for (int i = 0; i < 5; i++) step(1'b1, 14'(80 + i), 16'($urandom), 1'b1, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
        reset_n_i = 1'b0;
        #1;
        chk("t6_wr_en_in_reset", 32'(bus.ram_wr_en_o), 0);
        chk("t6_busy_in_reset", 32'(bus.busy_o), 0);
        q.delete();
        m_ovf = 1'b0;
        m_drops = 0;
        m_vvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        c0 = commits;
        idle(5);
        chk("t6_no_commits", commits - c0, 0);
        chk("t6_drops", 32'(bus.drop_count_o), 0);

        for (int i = 0; i < 300; i++) step(1'b1, 14'(i), 16'(i), 1'b1, '0, 1'b0);
        chk("sat_drops", 32'(bus.drop_count_o), 255);
        step(1'b1, '0, '0, 1'b1, '0, 1'b1);
        chk("clr_with_drop", 32'(bus.drop_count_o), 1);
        chk("clr_with_drop_ovf", 32'(bus.overflow_o), 1);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        idle(10);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1) == 1, 14'($urandom_range(0, 31)), 16'($urandom),
                 $urandom_range(0, 9) < 4, 14'($urandom_range(0, 31)), $urandom_range(0, 19) == 0);
        idle(12);
        chk("final_busy", 32'(bus.busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
